// File: rtl/l1_writeback_buffer.sv
// Eviction write-back buffer: circular FIFO of dirty lines drained to pmem one
// write at a time, with in-place coalescing and a newest-wins read snoop.
module l1_writeback_buffer #(
  parameter int DEPTH   = 2,
  parameter int LINE_W  = 128,
  parameter int LADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_push,
  input  logic [LADDR_W-1:0] wb_laddr,
  input  logic [LINE_W-1:0]  wb_line,
  output logic               wb_full,
  output logic               wb_empty,
  input  logic [LADDR_W-1:0] snoop_laddr,
  output logic               snoop_hit,
  output logic [LINE_W-1:0]  snoop_line,
  input  logic               rd_busy,
  output logic [15:0]        pmem_address,
  output logic [LINE_W-1:0]  pmem_wdata,
  output logic               pmem_write,
  input  logic               pmem_resp,
  output logic               err_overflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, WRITE} state_e;

  state_e                          state_q, state_d;
  logic [DEPTH-1:0]                valid_q, valid_d;
  logic [DEPTH-1:0][LADDR_W-1:0]   laddr_q, laddr_d;
  logic [DEPTH-1:0][LINE_W-1:0]    line_q, line_d;
  logic [PW-1:0]                   head_q, head_d, tail_q, tail_d;
  logic [PW:0]                     count_q, count_d;
  logic                            pmem_write_q, pmem_write_d;
  logic [15:0]                     pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0]               pmem_wdata_q, pmem_wdata_d;
  logic                            err_q, err_d;

  logic          start, pop, full, accept, head_busy, merge;
  logic [PW-1:0] merge_idx, sidx;

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign start     = (state_q == IDLE) && (count_q != '0) && !rd_busy;
  assign pop       = (state_q == WRITE) && pmem_resp;
  // A pop frees the head slot this cycle, so a push alongside it still fits.
  assign accept    = wb_push && (!full || pop);
  // The head being latched this cycle is already in flight: never merge into it.
  assign head_busy = (state_q == WRITE) || start;

  always_comb begin
    merge     = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && laddr_q[i] == wb_laddr && !(head_busy && PW'(i) == head_q)) begin
        merge     = 1'b1;
        merge_idx = PW'(i);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    laddr_d = laddr_q;
    line_d  = line_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (accept) begin
      if (merge) begin
        line_d[merge_idx] = wb_line;
      end else begin
        valid_d[tail_q] = 1'b1;
        laddr_d[tail_q] = wb_laddr;
        line_d[tail_q]  = wb_line;
        tail_d          = tail_q + 1'b1;
      end
    end
    count_d = count_q + (PW+1)'(accept && !merge) - (PW+1)'(pop);
    err_d   = err_q | (wb_push && !accept);
  end

  always_comb begin
    state_d        = state_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    case (state_q)
      IDLE: if (start) begin
        state_d        = WRITE;
        pmem_write_d   = 1'b1;
        pmem_address_d = 16'({laddr_q[head_q], 4'b0000});
        pmem_wdata_d   = line_q[head_q];
      end
      WRITE: if (pmem_resp) begin
        state_d      = IDLE;
        pmem_write_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Walk oldest to newest so the newest matching entry wins.
  always_comb begin
    snoop_hit  = 1'b0;
    snoop_line = '0;
    sidx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sidx = head_q + PW'(i);
      if (valid_q[sidx] && laddr_q[sidx] == snoop_laddr) begin
        snoop_hit  = 1'b1;
        snoop_line = line_q[sidx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      laddr_q        <= '0;
      line_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      laddr_q        <= laddr_d;
      line_q         <= line_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      err_q          <= err_d;
    end
  end

  assign wb_full      = full;
  assign wb_empty     = (count_q == '0) && (state_q == IDLE);
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign err_overflow = err_q;

endmodule
